melody_sequencer: RTL

- Record/playback controller in front of the `music` tone generator. It owns the generator's 4-bit `num` input.
- In live mode it passes keypad codes straight through.
- In record mode it also captures each key press into a note buffer.
- In play mode it replays the buffer with fixed note and gap durations, then returns to live mode.

---
 rtl/melody_sequencer_if.sv | 29 ++
 rtl/melody_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Handshake/bus bundle between a keypad/command source and melody_sequencer.
// master: drives key_num, key_valid, rec_start, play_start, stop; observes the rest.
// slave : the sequencer; drives num_out, state, count, overflow, done.
interface melody_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    key_num;
  logic          key_valid;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic [3:0]    num_out;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;

  modport master (
    output key_num, key_valid, rec_start, play_start, stop,
    input  num_out, state, count, overflow, done
  );

  modport slave (
    input  key_num, key_valid, rec_start, play_start, stop,
    output num_out, state, count, overflow, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Record/playback controller feeding the 4-bit num input of the tone generator.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      melody_sequencer_if.slave:
//            in : key_num, key_valid, rec_start, play_start, stop
//            out: num_out, state (0 IDLE, 1 RECORD, 2 PLAY_NOTE, 3 PLAY_GAP),
//                 count, overflow (sticky), done (one-cycle pulse)
// All outputs come straight from registers.
module melody_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 2500000,
  parameter int NOTE_LEN = 4,
  parameter int GAP_LEN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LMAX = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int TW   = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam int GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECORD    = 2'd1,
    S_PLAY_NOTE = 2'd2,
    S_PLAY_GAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    num_q, num_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    mem_q [DEPTH];
  logic          mem_we;

  logic tick, note_end, gap_end, advance, has_next, storable;

  always_comb begin
    tick     = ((state_q == S_PLAY_NOTE) || (state_q == S_PLAY_GAP)) &&
               (presc_q == PW'(TICK_DIV - 1));
    note_end = tick && (tcnt_q == TW'(NOTE_LEN - 1));
    gap_end  = tick && (tcnt_q == TW'(GAP_LAST));
    has_next = (CW'(idx_q) + CW'(1)) < count_q;
    storable = (bus.key_num == 4'd1) ||
               ((bus.key_num >= 4'd3) && (bus.key_num <= 4'd12));
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    mem_we  = 1'b0;
    advance = 1'b0;

    if (bus.stop) begin
      state_d = S_IDLE;
      num_d   = bus.key_num;
      presc_d = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          num_d   = bus.key_num;
          presc_d = '0;
          tcnt_d  = '0;
          if (bus.rec_start) begin
            state_d = S_RECORD;
            count_d = '0;
            ovf_d   = 1'b0;
          end else if (bus.play_start) begin
            if (count_q != '0) begin
              state_d = S_PLAY_NOTE;
              idx_d   = '0;
              num_d   = mem_q[0];
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_RECORD: begin
          num_d = bus.key_num;
          if (bus.rec_start) begin
            count_d = '0;
            ovf_d   = 1'b0;
          end else if (bus.key_valid) begin
            if (storable) begin
              if (count_q < CW'(DEPTH)) begin
                mem_we  = 1'b1;
                count_d = count_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else if (bus.key_num == 4'd2) begin
              state_d = S_IDLE;
            end
          end
        end
        S_PLAY_NOTE: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) tcnt_d = tcnt_q + TW'(1);
          if (note_end) begin
            tcnt_d = '0;
            if (GAP_LEN > 0) begin
              state_d = S_PLAY_GAP;
              num_d   = 4'd0;
            end else begin
              advance = 1'b1;
            end
          end
        end
        S_PLAY_GAP: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) tcnt_d = tcnt_q + TW'(1);
          if (gap_end) begin
            tcnt_d  = '0;
            advance = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // End of a note slot (gap end, or note end when there is no gap).
      if (advance) begin
        if (has_next) begin
          idx_d   = idx_q + IW'(1);
          state_d = S_PLAY_NOTE;
          num_d   = mem_q[idx_q + IW'(1)];
        end else begin
          state_d = S_IDLE;
          num_d   = 4'd0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[IW-1:0]] <= bus.key_num;
  end

  assign bus.num_out  = num_q;
  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
endmodule
